led_pwm_bank: RTL and testbench
===============================

LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of LED channels (1..16).
REQ-002 SHALL have parameter DUTY_W, default 8: duty and PWM counter width (2..16).
REQ-003 SHALL have parameter PRESC_DIV, default 391: clk cycles per PWM tick (>=1).
REQ-004 SHALL have parameter BLINK_W, default 7: blink counter width (>=1).
REQ-005 SHALL have port clk  in  1  single clock; all state is on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_valid  in  1  configuration write request.
REQ-008 SHALL have port wr_ready  out  1  write accept; combinational.
REQ-009 SHALL have port wr_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
REQ-010 SHALL have port wr_mode  in  2  mode: 0 off, 1 on, 2 PWM, 3 blink-PWM.
REQ-011 SHALL have port wr_duty  in  DUTY_W  duty value.
REQ-012 SHALL have port led  out  NUM_CH  registered LED drive.
REQ-013 SHALL have port pending  out  NUM_CH  per-channel shadow-update-pending flags.
REQ-014 SHALL have port period_end  out  1  one-cycle strobe on the last cycle of each PWM period.

Function
REQ-015 SHALL count a prescaler 0..PRESC_DIV-1, wrapping to 0, with tick high while the count equals PRESC_DIV-1; PRESC_DIV=1 gives tick every cycle.
REQ-016 SHALL increment pwm_cnt (DUTY_W bits) on each tick, wrapping from 2^DUTY_W-1 to 0.
REQ-017 SHALL drive period_end = tick AND pwm_cnt == 2^DUTY_W-1, combinationally.
REQ-018 SHALL increment blink_cnt (BLINK_W bits) on period_end, wrapping; blink_phase = blink_cnt MSB.
REQ-019 SHALL hold per channel an active {mode, duty}, a shadow {mode, duty} and a pending bit.
REQ-020 SHALL drive wr_ready = NOT pending[wr_ch] when wr_ch < NUM_CH, and 1 otherwise.
REQ-021 SHALL, on wr_valid AND wr_ready with wr_ch < NUM_CH, load shadow[wr_ch] and set pending[wr_ch].
REQ-022 SHALL accept and discard writes with wr_ch >= NUM_CH, changing no state.
REQ-023 SHALL, on period_end, copy shadow to active for every pending channel and clear those pending bits in the same edge.
REQ-024 SHALL treat a write accepted in the period_end cycle as a new pending update, applied at the next period_end and not the current one.
REQ-025 SHALL compute the next led[i] as: mode 0 -> 0; mode 1 -> 1; mode 2 -> (pwm_cnt < duty); mode 3 -> blink_phase AND (pwm_cnt < duty).
REQ-026 SHALL register led, giving one clk of latency from counter and active state to pin.
REQ-027 SHALL keep duty 0 off for the whole period in modes 2 and 3; duty 2^DUTY_W-1 is on for 2^DUTY_W-1 of 2^DUTY_W ticks.
REQ-028 SHALL keep configuration changes glitch-free: active settings change only at period boundaries, so no partial PWM periods occur.

Reset
REQ-029 SHALL, while reset is high, asynchronously clear the prescaler, pwm_cnt, blink_cnt, all active and shadow mode/duty, all pending bits and led.
REQ-030 SHALL, on reset mid-operation, drop led to 0 without waiting for a clock edge and discard any pending update.
REQ-031 SHALL, out of reset, present wr_ready=1 for all valid channels; the first tick occurs PRESC_DIV cycles after reset release.

Verification (NUM_CH=3, DUTY_W=4, PRESC_DIV=2, BLINK_W=2; period = 32 clk)
REQ-032 SHALL test reset: hold reset 5 cycles, then release -> led=000, pending=000, wr_ready=1, first period_end at cycle 32.
REQ-033 SHALL test PWM: write ch0 mode 2 duty 4 mid-period -> pending[0]=1 until period_end; afterwards led0 is high 8 of every 32 cycles, delayed 1 cycle.
REQ-034 SHALL test backpressure: two back-to-back writes to ch1 -> the second stalls with wr_ready=0 until the cycle after period_end, is then accepted, and takes effect one period later.
REQ-035 SHALL test blink: ch2 mode 3 duty 15 -> led2 is high 30/32 cycles in periods with blink_cnt[1]=1, and 0 for 2 periods of every 4.
REQ-036 SHALL test an out-of-range write and a boundary collision: wr_ch=3 with wr_valid -> wr_ready=1 and no state change; a write to ch0 in the period_end cycle -> applied at the following period_end.
REQ-037 SHALL test async reset mid-period with ch0 on and ch1 pending -> led=000 and pending=000 before the next clk edge.

Source files
------------

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM bank. A shared prescaler, PWM counter and blink counter
// drive per-channel lanes that hold shadowed configuration applied only at period end.

module led_pwm_lane #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              period_end,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              blink_phase,
  output logic              led,
  output logic              pending
);
  typedef struct packed {
    logic [1:0]        mode;
    logic [DUTY_W-1:0] duty;
  } cfg_t;

  cfg_t sh, act;
  logic led_nxt;

  always_comb begin
    led_nxt = 1'b0;
    unique case (act.mode)
      2'd0: led_nxt = 1'b0;
      2'd1: led_nxt = 1'b1;
      2'd2: led_nxt = (pwm_cnt < act.duty);
      2'd3: led_nxt = blink_phase && (pwm_cnt < act.duty);
      default: led_nxt = 1'b0;
    endcase
  end

  // A write can only land while not pending, so a write in the period_end cycle
  // is never copied on that same edge; it waits for the next boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      act     <= '0;
      pending <= 1'b0;
      led     <= 1'b0;
    end else begin
      if (wr_en) begin
        sh      <= '{mode: wr_mode, duty: wr_duty};
        pending <= 1'b1;
      end else if (period_end) begin
        pending <= 1'b0;
      end
      if (period_end && pending) act <= sh;
      led <= led_nxt;
    end
  end
endmodule

module led_pwm_bank #(
  parameter int NUM_CH    = 4,
  parameter int DUTY_W    = 8,
  parameter int PRESC_DIV = 391,
  parameter int BLINK_W   = 7,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] pending,
  output logic              period_end
);
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0]      presc;
  logic               tick;
  logic [DUTY_W-1:0]  pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               in_range;
  logic               pend_sel;
  logic [NUM_CH-1:0]  wr_en;

  assign tick        = (presc == PRESC_LAST);
  assign period_end  = tick && (pwm_cnt == '1);
  assign blink_phase = blink_cnt[BLINK_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick)       pwm_cnt   <= pwm_cnt + DUTY_W'(1);
      if (period_end) blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Out-of-range channels are always ready so the writer never stalls on them.
  always_comb begin
    in_range = ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (wr_ch == CH_W'(i)) pend_sel = pending[i];
    wr_ready = in_range ? ~pend_sel : 1'b1;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign wr_en[gi] = wr_valid && wr_ready && in_range && (wr_ch == CH_W'(gi));

    led_pwm_lane #(.DUTY_W(DUTY_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en[gi]),
      .wr_mode    (wr_mode),
      .wr_duty    (wr_duty),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt),
      .blink_phase(blink_phase),
      .led        (led[gi]),
      .pending    (pending[gi])
    );
  end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: NUM_CH=3, DUTY_W=4, PRESC_DIV=2, BLINK_W=2 (32-clk period).
// cyc counts rising edges since reset release; values are sampled 1 time unit after each edge.

module tb_led_pwm_bank;
  logic       clk, reset, wr_valid, wr_ready, period_end;
  logic [1:0] wr_ch, wr_mode;
  logic [3:0] wr_duty;
  logic [2:0] led, pending;

  int cyc, errors, checks;

  led_pwm_bank #(.NUM_CH(3), .DUTY_W(4), .PRESC_DIV(2), .BLINK_W(2)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_duty(wr_duty),
    .led(led), .pending(pending), .period_end(period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic drive_wr(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_mode  = mode;
    wr_duty  = duty;
  endtask

  initial begin
    int hi;
    int bc[4];
    errors = 0; checks = 0; cyc = 0;
    reset = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_mode = '0; wr_duty = '0;

    // reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    reset = 1'b0;
    cyc = 0;
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      wr_ch = 2'(ch);
      #1;
      chk("rst_ready", 32'(wr_ready), 32'h1);
    end
    wr_ch = '0;
    chk("rst_period_end", 32'(period_end), 32'h0);
    while (period_end !== 1'b1 && cyc < 40) step();
    chk("first_period_end_cyc", 32'(cyc), 32'd31);

    // PWM: ch0 mode 2 duty 4 written mid-period
    run_to(40);
    drive_wr(2'd0, 2'd2, 4'd4);
    #1;
    chk("pwm_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    chk("pwm_pending_set", 32'(pending[0]), 32'h1);
    run_to(63);
    chk("pwm_pending_hold", 32'(pending[0]), 32'h1);
    chk("pwm_pe", 32'(period_end), 32'h1);
    step();
    chk("pwm_pending_clr", 32'(pending[0]), 32'h0);
    chk("pwm_led_lat", 32'(led[0]), 32'h0);
    hi = int'(led[0]);
    for (int k = 0; k < 31; k++) begin
      step();
      hi += int'(led[0]);
      if (cyc == 65) chk("pwm_led_rise", 32'(led[0]), 32'h1);
      if (cyc == 72) chk("pwm_led_last", 32'(led[0]), 32'h1);
      if (cyc == 73) chk("pwm_led_fall", 32'(led[0]), 32'h0);
    end
    chk("pwm_high_count", 32'(hi), 32'd8);

    // backpressure: back-to-back writes to ch1
    run_to(100);
    drive_wr(2'd1, 2'd1, 4'd0);
    #1;
    chk("bp_ready1", 32'(wr_ready), 32'h1);
    step();
    wr_mode = 2'd2; wr_duty = 4'd8;
    #1;
    chk("bp_stall", 32'(wr_ready), 32'h0);
    chk("bp_pending", 32'(pending[1]), 32'h1);
    while (wr_ready !== 1'b1 && cyc < 200) step();
    chk("bp_release_cyc", 32'(cyc), 32'd128);
    chk("bp_led_before", 32'(led[1]), 32'h0);
    step();
    wr_valid = 1'b0;
    chk("bp_pending2", 32'(pending[1]), 32'h1);
    chk("bp_led_on", 32'(led[1]), 32'h1);
    run_to(160);
    chk("bp_applied", 32'(pending[1]), 32'h0);
    chk("bp_led_160", 32'(led[1]), 32'h1);
    run_to(176);
    chk("bp_led_176", 32'(led[1]), 32'h1);
    step();
    chk("bp_led_177", 32'(led[1]), 32'h0);

    // blink: ch2 mode 3 duty 15, active from edge 192
    run_to(180);
    drive_wr(2'd2, 2'd3, 4'd15);
    #1;
    chk("blink_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    run_to(192);
    for (int p = 0; p < 4; p++) bc[p] = 0;
    for (int k = 0; k < 128; k++) begin
      step();
      bc[k/32] += int'(led[2]);
    end
    chk("blink_p0", 32'(bc[0]), 32'd30);
    chk("blink_p1", 32'(bc[1]), 32'd30);
    chk("blink_p2", 32'(bc[2]), 32'd0);
    chk("blink_p3", 32'(bc[3]), 32'd0);

    // out-of-range channel write
    drive_wr(2'd3, 2'd1, 4'd5);
    #1;
    chk("oor_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0; wr_ch = '0;
    chk("oor_pending", 32'(pending), 32'h0);

    // write to ch0 in the period_end cycle
    run_to(351);
    chk("coll_pe", 32'(period_end), 32'h1);
    drive_wr(2'd0, 2'd1, 4'd0);
    #1;
    chk("coll_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    chk("coll_pending", 32'(pending[0]), 32'h1);
    run_to(361);
    chk("coll_led_old", 32'(led[0]), 32'h0);
    chk("coll_pending_hold", 32'(pending[0]), 32'h1);
    run_to(384);
    chk("coll_applied", 32'(pending[0]), 32'h0);
    run_to(393);
    chk("coll_led_new", 32'(led[0]), 32'h1);

    // async reset mid-period with ch0 on and ch1 pending
    drive_wr(2'd1, 2'd0, 4'd0);
    #1;
    chk("ar_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0;
    chk("ar_pending_pre", 32'(pending), 32'h2);
    chk("ar_led_pre", 32'(led), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_led_async", 32'(led), 32'h0);
    chk("ar_pending_async", 32'(pending), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_led_after", 32'(led), 32'h0);
    chk("ar_pending_after", 32'(pending), 32'h0);
    chk("ar_ready_after", 32'(wr_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
